// File: rtl/panel_pkg.sv
// Shared definitions for the panel input sequencer: widths, parameter
// defaults, FSM state encoding and a small state-index helper.
package panel_pkg;

  // Output field widths seen by the downstream credit/state/display chain.
  localparam int CREDIT_W = 4;
  localparam int ESTADO_W = 3;

  // Default parameter values for the sequencer and its debouncers.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned MAX_CREDIT_DEF      = 15;
  localparam int unsigned COST_DEF            = 1;
  localparam int unsigned NUM_STATES_DEF      = 6;

  // FSM encodings kept as plain constants so older code can match on them.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ADVANCE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ADVANCE = ST_ADVANCE,
    HOLD    = ST_HOLD
  } fsm_state_e;

  // Next state index with wrap from the last index back to 0.
  function automatic logic [ESTADO_W-1:0] next_estado(
    input logic [ESTADO_W-1:0] cur,
    input logic [ESTADO_W-1:0] last
  );
    return (cur == last) ? '0 : cur + 1'b1;
  endfunction

endpackage

// File: rtl/panel_input_sequencer_btn_debounce.sv
// One panel button: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle event on each rising edge of that level.
module btn_debounce
  import panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic ev
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             ev_q, ev_d;

  // Synchronise, count consecutive disagreeing cycles, commit the new level
  // once the count has reached its last value, and flag the rising edge.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    ev_d = level_d & ~level_q;
  end

  // State registers; everything clears on reset so no event follows release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      ev_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      ev_q    <= ev_d;
    end
  end

  assign level = level_q;
  assign ev    = ev_q;

endmodule

// File: rtl/panel_input_sequencer.sv
// Panel front end: debounces coin/advance/cancel buttons, keeps a saturating
// credit count and a wrapping state index, and strobes avance once per
// accepted advance press.
// Handshake: there is no back-pressure; avance is a one-cycle strobe and
// sw_credito/estado are registered levels the consumer may sample any cycle.
module panel_input_sequencer
  import panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned MAX_CREDIT      = MAX_CREDIT_DEF,
  parameter int unsigned COST            = COST_DEF,
  parameter int unsigned NUM_STATES      = NUM_STATES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_btn,
  input  logic                adv_btn,
  input  logic                cancel_btn,
  output logic [CREDIT_W-1:0] sw_credito,
  output logic                avance,
  output logic [ESTADO_W-1:0] estado,
  output logic                busy
);

  localparam int CW1 = CREDIT_W + 1;
  localparam logic [CREDIT_W-1:0] COST_C     = CREDIT_W'(COST);
  localparam logic [CW1-1:0]      COST_X     = CW1'(COST);
  localparam logic [CW1-1:0]      MAX_X      = CW1'(MAX_CREDIT);
  localparam logic [ESTADO_W-1:0] ESTADO_END = ESTADO_W'(NUM_STATES - 1);

  logic coin_ev, adv_ev, cancel_ev;
  logic coin_level, adv_level, cancel_level;
  logic unused_levels;

  fsm_state_e          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ESTADO_W-1:0] estado_q, estado_d;
  logic                avance_q, avance_d;
  logic                debit;
  logic [CW1-1:0]      credit_sum;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (coin_btn),
    .level  (coin_level),
    .ev     (coin_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adv (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (adv_btn),
    .level  (adv_level),
    .ev     (adv_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (cancel_btn),
    .level  (cancel_level),
    .ev     (cancel_ev)
  );

  // Only the advance level matters to the FSM; the other two are events only.
  assign unused_levels = coin_level ^ cancel_level;

  // Sequencing FSM: cancel overrides everything, otherwise IDLE accepts a
  // covered advance, ADVANCE lasts one cycle, HOLD waits for button release.
  always_comb begin
    state_d  = state_q;
    estado_d = estado_q;
    avance_d = 1'b0;
    debit    = 1'b0;
    if (cancel_ev) begin
      state_d  = IDLE;
      estado_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (adv_ev && (credit_q >= COST_C)) begin
            state_d  = ADVANCE;
            avance_d = 1'b1;
          end
        end
        ADVANCE: begin
          debit    = 1'b1;
          estado_d = next_estado(estado_q, ESTADO_END);
          state_d  = HOLD;
        end
        HOLD: begin
          if (!adv_level) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Credit update: +1 per coin, -COST in ADVANCE, saturate at MAX_CREDIT;
  // a cancel zeroes the count and discards a same-cycle coin.
  always_comb begin
    credit_sum = {1'b0, credit_q} + CW1'(coin_ev);
    if (debit) begin
      credit_sum = (credit_sum >= COST_X) ? (credit_sum - COST_X) : '0;
    end
    if (credit_sum > MAX_X) credit_sum = MAX_X;
    credit_d = cancel_ev ? '0 : credit_sum[CREDIT_W-1:0];
  end

  // Registered outputs and FSM state; reset aborts straight to idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      estado_q <= '0;
      avance_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      estado_q <= estado_d;
      avance_q <= avance_d;
    end
  end

  assign sw_credito = credit_q;
  assign estado     = estado_q;
  // A cancel landing in the ADVANCE cycle also suppresses the strobe.
  assign avance     = avance_q & ~cancel_ev;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_panel_input_sequencer.sv
// Bench for panel_input_sequencer with a short debounce window. Expected
// credit/state/strobe counts come from a press-level model of the panel.
module tb_panel_input_sequencer;

  localparam int D    = 4;
  localparam int MAXC = 15;
  localparam int COST = 1;
  localparam int NS   = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_btn = 1'b0;
  logic       adv_btn = 1'b0;
  logic       cancel_btn = 1'b0;
  logic [3:0] sw_credito;
  logic       avance;
  logic [2:0] estado;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int av_cnt   = 0;
  int m_credit = 0;
  int m_estado = 0;
  int m_av     = 0;

  // clock / reset block
  always #5 clk = ~clk;

  panel_input_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .MAX_CREDIT     (MAXC),
    .COST           (COST),
    .NUM_STATES     (NS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin_btn   (coin_btn),
    .adv_btn    (adv_btn),
    .cancel_btn (cancel_btn),
    .sw_credito (sw_credito),
    .avance     (avance),
    .estado     (estado),
    .busy       (busy)
  );

  // Count every strobe cycle seen away from the active edge.
  always @(negedge clk) if (avance === 1'b1) av_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: one call per clean, fully debounced press
  task automatic model_coin();
    m_credit = (m_credit + 1 > MAXC) ? MAXC : m_credit + 1;
  endtask

  task automatic model_adv();
    if (m_credit >= COST) begin
      m_credit = m_credit - COST;
      m_estado = (m_estado + 1) % NS;
      m_av++;
    end
  endtask

  task automatic model_cancel();
    m_credit = 0;
    m_estado = 0;
  endtask

  // driver: called at a negedge, returns at a negedge
  task automatic press(input int which, input int hold, input int gap);
    case (which)
      0: coin_btn = 1'b1;
      1: adv_btn = 1'b1;
      default: cancel_btn = 1'b1;
    endcase
    repeat (hold) @(negedge clk);
    coin_btn = 1'b0;
    adv_btn = 1'b0;
    cancel_btn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_credit"}, sw_credito, m_credit);
    chk({tag, "_estado"}, estado, m_estado);
    chk({tag, "_avcount"}, av_cnt, m_av);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin : stim
    int hi_first;
    int hi_n;
    int av0;
    int busy_drop;
    int t;
    int r;
    logic busy_k6;
    logic busy_k7;

    // reset and idle: buttons wiggle while held in reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      coin_btn = 1'($urandom_range(0, 1));
      adv_btn = 1'($urandom_range(0, 1));
      cancel_btn = 1'($urandom_range(0, 1));
      chk("in_reset_outputs", {sw_credito, avance, estado, busy}, 0);
    end
    coin_btn = 1'b0;
    adv_btn = 1'b0;
    cancel_btn = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_model("post_reset");
    press(1, 8, 10);
    model_adv();
    check_model("adv_no_credit");

    // coin then advance, with exact strobe latency
    for (int i = 0; i < 3; i++) begin
      press(0, 8, 10);
      model_coin();
      chk("coin_step_credit", sw_credito, m_credit);
    end
    adv_btn = 1'b1;
    hi_first = -1;
    hi_n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (avance === 1'b1) begin
        hi_n++;
        if (hi_first < 0) hi_first = k;
      end
    end
    adv_btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("avance_latency", hi_first, 2 + D + 1);
    chk("avance_width", hi_n, 1);
    model_adv();
    check_model("first_advance");

    // saturation, then six advances through the wrap
    press(2, 8, 10);
    model_cancel();
    for (int i = 0; i < 20; i++) begin
      press(0, 6, 9);
      model_coin();
    end
    chk("saturated_credit", sw_credito, 15);
    for (int i = 0; i < 6; i++) begin
      press(1, 6, 10);
      model_adv();
      chk("wrap_estado", estado, m_estado);
    end
    check_model("after_wrap");

    // bounce rejection on the coin button
    t = 0;
    while (t < 30) begin
      r = $urandom_range(1, D - 1);
      coin_btn = 1'b1;
      repeat (r) @(negedge clk);
      t += r;
      r = $urandom_range(1, 3);
      coin_btn = 1'b0;
      repeat (r) @(negedge clk);
      t += r;
    end
    repeat (10) @(negedge clk);
    check_model("chatter");
    press(0, 10, 10);
    model_coin();
    check_model("stable_after_chatter");

    // held advance: one strobe, busy through the release debounce
    press(2, 8, 10);
    model_cancel();
    for (int i = 0; i < 5; i++) begin
      press(0, 6, 9);
      model_coin();
    end
    av0 = av_cnt;
    busy_drop = 0;
    adv_btn = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k >= 7 && busy !== 1'b1) busy_drop++;
    end
    chk("held_busy_drops", busy_drop, 0);
    chk("held_single_strobe", av_cnt - av0, 1);
    adv_btn = 1'b0;
    busy_k6 = 1'b0;
    busy_k7 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 6) busy_k6 = busy;
      if (k == 7) busy_k7 = busy;
    end
    chk("busy_until_release", busy_k6, 1);
    chk("idle_after_release", busy_k7, 0);
    model_adv();
    check_model("held_release");
    press(1, 8, 10);
    model_adv();
    check_model("second_press");

    // cancel priority over a simultaneous coin
    press(2, 8, 10);
    model_cancel();
    for (int i = 0; i < 7; i++) begin
      press(0, 6, 9);
      model_coin();
    end
    for (int i = 0; i < 3; i++) begin
      press(1, 6, 10);
      model_adv();
    end
    chk("pre_cancel_credit", sw_credito, 4);
    chk("pre_cancel_estado", estado, 3);
    coin_btn = 1'b1;
    cancel_btn = 1'b1;
    repeat (8) @(negedge clk);
    coin_btn = 1'b0;
    cancel_btn = 1'b0;
    repeat (10) @(negedge clk);
    model_cancel();
    check_model("cancel_vs_coin");

    // cancel priority over a simultaneous advance
    press(0, 6, 9);
    model_coin();
    press(0, 6, 9);
    model_coin();
    adv_btn = 1'b1;
    cancel_btn = 1'b1;
    repeat (8) @(negedge clk);
    adv_btn = 1'b0;
    cancel_btn = 1'b0;
    repeat (10) @(negedge clk);
    model_cancel();
    check_model("cancel_vs_adv");

    // reset asserted while the FSM holds
    press(0, 6, 9);
    model_coin();
    press(0, 6, 9);
    model_coin();
    adv_btn = 1'b1;
    repeat (10) @(negedge clk);
    chk("hold_busy", busy, 1);
    model_adv();
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {sw_credito, avance, estado, busy}, 0);
    model_cancel();
    adv_btn = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_model("after_mid_reset");

    // random clean presses against the model
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        press(0, $urandom_range(5, 12), $urandom_range(9, 14));
        model_coin();
      end else if (r < 9) begin
        press(1, $urandom_range(5, 12), $urandom_range(9, 14));
        model_adv();
      end else begin
        press(2, $urandom_range(5, 12), $urandom_range(9, 14));
        model_cancel();
      end
      check_model($sformatf("rand%0d", i));
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
